// File: rtl/reg_to_obi_bridge_pkg.sv
// rtl/reg_to_obi_bridge_pkg.sv - bus types, FSM states and constants for the reg-to-OBI bridge
package reg_to_obi_bridge_pkg;

  localparam int WDOG_W = 16;
  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } bridge_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/reg_to_obi_bridge_if.sv
// rtl/reg_to_obi_bridge_if.sv - register-bus and OBI signal bundle seen by the bridge
interface reg_to_obi_bridge_if;
  import reg_to_obi_bridge_pkg::*;

  reg_req_t  reg_req_i;
  reg_rsp_t  reg_rsp_o;
  obi_req_t  obi_req_o;
  obi_resp_t obi_resp_i;
  logic      timeout_o;

  modport slave (
    input  reg_req_i,
    input  obi_resp_i,
    output reg_rsp_o,
    output obi_req_o,
    output timeout_o
  );

  modport master (
    output reg_req_i,
    output obi_resp_i,
    input  reg_rsp_o,
    input  obi_req_o,
    input  timeout_o
  );

endinterface

// File: rtl/reg_to_obi_bridge.sv
// rtl/reg_to_obi_bridge.sv - single-outstanding register-bus responder issuing OBI transactions
module reg_to_obi_bridge
  import reg_to_obi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clk_i,
  input logic                rst_ni,
  reg_to_obi_bridge_if.slave bus
);

  localparam bit                WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [WDOG_W-1:0] TMO_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e     state_q, state_d;
  logic [31:0]       addr_q, wdata_q, rdata_q, rdata_d;
  logic              we_q;
  logic [3:0]        be_q;
  logic              error_q, error_d;
  logic              orphan_q, orphan_d;
  logic              timeout_q, timeout_d;
  logic              load;
  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              wdog_fire, rsp_hit;

  // cnt_q counts completed REQ/WAIT cycles, so firing on TMO_LAST caps the total at TIMEOUT_CYCLES
  assign wdog_fire = WDOG_EN && (cnt_q >= TMO_LAST);
  assign rsp_hit   = bus.obi_resp_i.rvalid && !orphan_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    orphan_d  = orphan_q;
    timeout_d = 1'b0;
    load      = 1'b0;
    if (orphan_q && bus.obi_resp_i.rvalid) begin
      orphan_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.reg_req_i.valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + WDOG_W'(1);
        if (bus.obi_resp_i.gnt) begin
          state_d = ST_WAIT;
        end else if (wdog_fire) begin
          state_d   = ST_RESP;
          rdata_d   = ERR_RDATA;
          error_d   = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + WDOG_W'(1);
        if (rsp_hit) begin
          state_d = ST_RESP;
          rdata_d = bus.obi_resp_i.rdata;
          error_d = 1'b0;
        end else if (wdog_fire) begin
          // the slave still owes this response; drop it when it eventually shows up
          state_d   = ST_RESP;
          rdata_d   = ERR_RDATA;
          error_d   = 1'b1;
          timeout_d = 1'b1;
          orphan_d  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      orphan_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      orphan_q  <= orphan_d;
      timeout_q <= timeout_d;
      if (load) begin
        addr_q  <= bus.reg_req_i.addr & ~32'h3;
        we_q    <= bus.reg_req_i.write;
        be_q    <= bus.reg_req_i.wstrb;
        wdata_q <= bus.reg_req_i.wdata;
      end
    end
  end

  always_comb begin
    bus.obi_req_o       = '0;
    bus.obi_req_o.req   = (state_q == ST_REQ);
    bus.obi_req_o.we    = we_q;
    bus.obi_req_o.be    = be_q;
    bus.obi_req_o.addr  = addr_q;
    bus.obi_req_o.wdata = wdata_q;
    bus.reg_rsp_o       = '0;
    if (state_q == ST_RESP) begin
      bus.reg_rsp_o.ready = 1'b1;
      bus.reg_rsp_o.rdata = rdata_q;
      bus.reg_rsp_o.error = error_q;
    end
  end

  assign bus.timeout_o = timeout_q;

endmodule

// File: doc/reg_to_obi_bridge.md
# reg_to_obi_bridge

Register-bus responder that turns each `reg_pkg` transaction into a single OBI initiator transaction. It is the reverse of the peripheral path's OBI-to-register conversion. Register-bus IPs such as DMA-like engines and debug/config masters use it to reach OBI slaves, including the peripheral subsystem. It is single-outstanding, and a timeout watchdog guarantees the register-bus master is always released.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255. Maximum number of cycles spent in REQ+WAIT before an error response is forced. 0 disables the watchdog. Range 0..65535.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `reg_req_i`  in  `reg_pkg::reg_req_t`  addr, write, wdata, wstrb, valid.
- `reg_rsp_o`  out  `reg_pkg::reg_rsp_t`  rdata, error, ready.
- `obi_req_o`  out  `obi_pkg::obi_req_t`  req, we, be, addr, wdata.
- `obi_resp_i`  in  `obi_pkg::obi_resp_t`  gnt, rvalid, rdata.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
The block uses a four-state FSM: IDLE, REQ, WAIT, RESP.

- **IDLE:** when `reg_req_i.valid`=1, register the request fields.
  - addr: bits [1:0] forced to 0.
  - we = write.
  - be = wstrb.
  - wdata.
  - Go to REQ.
- **REQ:** drive `obi_req_o.req`=1 with the registered fields, which stay stable.
  - On gnt, go to WAIT.
  - Do not deassert req before gnt, except on timeout.
- **WAIT:** req=0.
  - On rvalid, capture rdata and set error=0.
  - Reads and writes both complete on rvalid; write rdata is captured but the value is don't-care.
  - Go to RESP.
- **RESP:** drive `reg_rsp_o.ready`=1 for exactly one cycle with the captured rdata/error, then go to IDLE.
- **Watchdog:** a 16-bit counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`, force RESP with error=1 and rdata=`ERR_RDATA` (32'hBADCAB1E), and pulse `timeout_o`.
  - REQ timeout: req drops immediately, and no OBI transaction is owed.
  - WAIT timeout: set an `orphan` flag. The next rvalid seen in any state while `orphan`=1 is discarded and clears the flag.
  - The orphan's rvalid always precedes the new transaction's rvalid, because OBI responses are in order. New requests are accepted while `orphan`=1.
- **Outputs outside RESP:** `reg_rsp_o` is all zero.
- **Reset:** all registers clear, FSM goes to IDLE, and `orphan` clears.
  - Reset values: `obi_req_o`='0, `reg_rsp_o`='0, `timeout_o`=0.
  - A reset mid-transaction abandons it silently.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Minimum latency: valid sampled in cycle t, req high in t+1, gnt in t+1, rvalid in t+2, ready in t+3. That is 4 cycles per access.
- The master holds valid and fields stable until it sees ready. ready and valid are coincident in the RESP cycle.
- IDLE is re-entered at t+4, and a new valid is sampled there. Back-to-back throughput is one access per 4 cycles.
- gnt and rvalid may arrive in the same cycle only if the slave violates OBI. rvalid in REQ is ignored unless it is an orphan.
- Watchdog boundary: a gnt or rvalid arriving in the same cycle the counter reaches `TIMEOUT_CYCLES` wins, and the timeout does not fire.

## Structure
- `reg_to_obi_pkg` holds:
  - the FSM state enum `bridge_state_e`;
  - `ERR_RDATA`;
  - the watchdog width localparam (16).
- A single flat module. The watchdog counter is inline; no sub-module is warranted.

## Test plan
- **Read, zero-wait slave:** read addr 0x2000_0013 → `obi_req_o.addr`=0x2000_0010, be=wstrb, we=0. Slave returns rdata 0xDEADBEEF one cycle after gnt → ready in cycle t+3 with rdata=0xDEADBEEF, error=0.
- **Write with gnt stalled 3 cycles:** req and fields stay stable for 4 cycles. wdata=0x12345678, be=4'b0101 reach the slave. ready comes 3 cycles later than the zero-wait case.
- **Back-to-back:** 8 alternating reads/writes with valid kept high → 8 OBI transactions in order, one ready per access, no duplicated or dropped requests.
- **Gnt timeout:** `TIMEOUT_CYCLES`=10, gnt never asserted.
  - req drops after 10 cycles.
  - `timeout_o` pulses once.
  - ready has error=1, rdata=0xBADCAB1E.
- **Rvalid timeout then late response:** gnt given, rvalid withheld past the timeout, then a new read is issued.
  - The late rvalid (0x1111_1111) is discarded.
  - The second rvalid (0x2222_2222) is returned for the new read.
- **Reset mid-transaction:** assert `rst_ni` low while in WAIT → all outputs go to 0 asynchronously. After release the FSM is in IDLE and the next access completes normally.
